// File: rtl/sqrt_arb_pkg.sv
// Shared types, default widths and helpers for the sqrt_arbiter slice.
package sqrt_arb_pkg;

  localparam int unsigned DEF_NUM_REQ         = 4;
  localparam int unsigned DEF_DATA_IN_WIDTH   = 24;
  localparam int unsigned DEF_FINAL_OUT_WIDTH = 24;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  // Width of a requester index; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sqrt_arb_rr_pick.sv
// Combinational round-robin priority picker: first set bit of req at or above ptr, wrapping.
module sqrt_arb_rr_pick
  import sqrt_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = idx_width(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_valid
);

  logic [IDX_W-1:0] idx;

  // Scan NUM_REQ positions starting at ptr; the first valid one wins.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (!any_valid && req[idx]) begin
        any_valid     = 1'b1;
        grant_idx     = idx;
        grant_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sqrt_arbiter.sv
// Round-robin front end sharing one iterative sqrt unit among NUM_REQ requesters.
// Optional feature: define SQRT_ARB_ZERO_BYPASS_EN to answer a zero radicand
// directly (IDLE -> RESP) without using the sqrt unit.
module sqrt_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = DEF_NUM_REQ,
  parameter int unsigned DATA_IN_WIDTH   = DEF_DATA_IN_WIDTH,
  parameter int unsigned FINAL_OUT_WIDTH = DEF_FINAL_OUT_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*DATA_IN_WIDTH-1:0]   req_radicand,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  input  logic [NUM_REQ-1:0]                 rsp_ready,
  output logic [FINAL_OUT_WIDTH-1:0]         rsp_data,
  output logic                               sq_valid_in,
  output logic [DATA_IN_WIDTH-1:0]           sq_radicand,
  input  logic                               sq_valid_out,
  input  logic [FINAL_OUT_WIDTH-1:0]         sq_result,
  output logic                               busy
);

  localparam int unsigned IW = idx_width(NUM_REQ);

  arb_state_t                 state, state_nxt;
  logic [IW-1:0]              ptr;
  logic [IW-1:0]              grant_q;
  logic [DATA_IN_WIDTH-1:0]   radicand_q;
  logic [FINAL_OUT_WIDTH-1:0] result_q;

  logic [NUM_REQ-1:0]         pick_oh;
  logic [IW-1:0]              pick_idx;
  logic                       pick_any;
  logic [DATA_IN_WIDTH-1:0]   pick_radicand;
  logic [IW-1:0]              ptr_nxt;
  logic                       accept;
  logic                       zero_bypass;

  sqrt_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IW)
  ) u_pick (
    .req       (req_valid),
    .ptr       (ptr),
    .grant_oh  (pick_oh),
    .grant_idx (pick_idx),
    .any_valid (pick_any)
  );

  assign pick_radicand = req_radicand[pick_idx*DATA_IN_WIDTH +: DATA_IN_WIDTH];
  assign accept        = (state == IDLE) && pick_any;
  assign ptr_nxt       = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
  assign sq_radicand   = radicand_q;
  assign busy          = (state != IDLE);

  // Decide whether an accepted request may skip the sqrt unit.
  always_comb begin
    zero_bypass = 1'b0;
`ifdef SQRT_ARB_ZERO_BYPASS_EN
    zero_bypass = accept && (pick_radicand == '0);
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and output decode; outputs are zero unless the state drives them.
  always_comb begin
    state_nxt   = state;
    req_ready   = '0;
    rsp_valid   = '0;
    rsp_data    = '0;
    sq_valid_in = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = pick_oh;
        if (pick_any) state_nxt = zero_bypass ? RESP : ISSUE;
      end
      ISSUE: begin
        sq_valid_in = 1'b1;
        state_nxt   = WAIT;
      end
      WAIT: begin
        if (sq_valid_out) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid[grant_q] = 1'b1;
        rsp_data           = result_q;
        if (rsp_ready[grant_q]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request/result latches and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      grant_q    <= '0;
      radicand_q <= '0;
      result_q   <= '0;
    end else begin
      if (accept) begin
        radicand_q <= pick_radicand;
        grant_q    <= pick_idx;
        ptr        <= ptr_nxt;
        if (zero_bypass) result_q <= '0;
      end
      if ((state == WAIT) && sq_valid_out) result_q <= sq_result;
    end
  end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Self-checking bench for sqrt_arbiter with a fixed-latency behavioural sqrt unit.
// Honours SQRT_ARB_ZERO_BYPASS_EN when choosing the zero-radicand expectations.
module tb_sqrt_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 24;
  localparam int unsigned OW  = 24;
  localparam int unsigned LSQ = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_radicand = '0;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready = '0;
  logic [OW-1:0]   rsp_data;
  logic            sq_valid_in;
  logic [W-1:0]    sq_radicand;
  logic            sq_valid_out;
  logic [OW-1:0]   sq_result;
  logic            busy;

  logic            model_pulse;
  logic            stray_pulse = 1'b0;
  logic [OW-1:0]   model_res;
  logic            model_busy;
  logic [7:0]      model_cnt;
  logic [W-1:0]    model_rad;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign sq_valid_out = model_pulse | stray_pulse;
  assign sq_result    = stray_pulse ? 24'h00ABCD : model_res;

  sqrt_arbiter #(
    .NUM_REQ         (N),
    .DATA_IN_WIDTH   (W),
    .FINAL_OUT_WIDTH (OW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_radicand (req_radicand),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .sq_valid_in  (sq_valid_in),
    .sq_radicand  (sq_radicand),
    .sq_valid_out (sq_valid_out),
    .sq_result    (sq_result),
    .busy         (busy)
  );

  function automatic logic [OW-1:0] isqrt(input logic [W-1:0] x);
    logic [31:0] r;
    logic [31:0] t;
    r = 0;
    for (int b = 11; b >= 0; b--) begin
      t = r | (32'd1 << b);
      if (64'(t) * 64'(t) <= 64'(x)) r = t;
    end
    return OW'(r);
  endfunction

  // Behavioural sqrt unit: done pulse LSQ cycles after the start pulse; reset with the block.
  always @(posedge clk) begin
    model_pulse <= 1'b0;
    if (rst) begin
      model_busy <= 1'b0;
      model_cnt  <= '0;
      model_res  <= '0;
      model_rad  <= '0;
    end else if (sq_valid_in) begin
      model_busy <= 1'b1;
      model_cnt  <= 8'(LSQ - 2);
      model_rad  <= sq_radicand;
    end else if (model_busy) begin
      if (model_cnt == 0) begin
        model_pulse <= 1'b1;
        model_res   <= isqrt(model_rad);
        model_busy  <= 1'b0;
      end else begin
        model_cnt <= model_cnt - 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    req_valid   = '0;
    rsp_ready   = '0;
    stray_pulse = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_vec(input int unsigned r, input logic [W-1:0] rad, input logic [OW-1:0] exp,
                         input int unsigned exp_lat, input int unsigned exp_pulses);
    int unsigned waitc;
    int unsigned lat;
    int unsigned pulses;
    logic        got;
    @(negedge clk);
    req_radicand[r*W +: W] = rad;
    req_valid[r]           = 1'b1;
    #1;
    waitc = 0;
    while (!req_ready[r] && waitc < 20) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    check("req_ready_onehot", 64'(req_ready), 64'd1 << r);
    @(posedge clk);
    #1 req_valid[r] = 1'b0;
    lat    = 0;
    pulses = 0;
    got    = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (sq_valid_in) pulses++;
      if (rsp_valid[r]) got = 1'b1;
    end
    check("rsp_latency", 64'(lat), 64'(exp_lat));
    check("sq_pulse_count", 64'(pulses), 64'(exp_pulses));
    check("rsp_valid_onehot", 64'(rsp_valid), 64'd1 << r);
    check("rsp_data", 64'(rsp_data), 64'(exp));
    check("sq_radicand_held", 64'(sq_radicand), 64'(rad));
    rsp_ready[r] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[r] = 1'b0;
    check("busy_after_rsp", 64'(busy), 64'd0);
    check("rsp_data_after_rsp", 64'(rsp_data), 64'd0);
  endtask

  typedef struct {
    int unsigned   req;
    logic [W-1:0]  rad;
    logic [OW-1:0] exp;
    int unsigned   lat;
    int unsigned   pulses;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int unsigned order[6];
    int unsigned exp_order[6];
    int unsigned nseen;
    int unsigned cyc;
    int unsigned g;
    logic        r2_ready;
    logic        seen;
    logic [N-1:0] hs;

    vecs[0] = '{0, 24'd144,     24'd12,   LSQ + 2, 1};
    vecs[1] = '{2, 24'hFFFFFF,  24'd4095, LSQ + 2, 1};
    vecs[2] = '{1, 24'd1,       24'd1,    LSQ + 2, 1};
    vecs[3] = '{3, 24'd81,      24'd9,    LSQ + 2, 1};
    vecs[4] = '{0, 24'd10000,   24'd100,  LSQ + 2, 1};
    vecs[5] = '{1, 24'd2,       24'd1,    LSQ + 2, 1};
`ifdef SQRT_ARB_ZERO_BYPASS_EN
    vecs[6] = '{3, 24'd0,       24'd0,    1,       0};
`else
    vecs[6] = '{3, 24'd0,       24'd0,    LSQ + 2, 1};
`endif
    exp_order = '{0, 1, 3, 0, 1, 3};

    // Reset state
    do_reset();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_sq_valid_in", 64'(sq_valid_in), 64'd0);
    check("rst_sq_radicand", 64'(sq_radicand), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    // Directed single requests
    for (int unsigned i = 0; i < 7; i++)
      run_vec(vecs[i].req, vecs[i].rad, vecs[i].exp, vecs[i].lat, vecs[i].pulses);

    // Backpressure on requester 1 while others wait and wave rsp_ready
    @(negedge clk);
    req_radicand[1*W +: W] = 24'd81;
    req_valid[1] = 1'b1;
    #1;
    cyc = 0;
    while (!req_ready[1] && cyc < 20) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("bp_accept", 64'(req_ready), 64'h2);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    req_radicand[0*W +: W] = 24'd4;
    req_radicand[2*W +: W] = 24'd9;
    req_radicand[3*W +: W] = 24'd16;
    req_valid = 4'b1101;
    rsp_ready = 4'b1101;
    cyc = 0;
    while (!rsp_valid[1] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    for (int unsigned i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 64'(rsp_valid), 64'h2);
      check("bp_rsp_data", 64'(rsp_data), 64'd9);
      check("bp_req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    req_valid    = '0;
    rsp_ready    = '0;
    rsp_ready[1] = 1'b1;
    @(posedge clk);
    #1 rsp_ready = '0;
    check("bp_done_busy", 64'(busy), 64'd0);

    // Fairness from reset: 0,1,3 held, requester 2 idle
    do_reset();
    req_radicand[0*W +: W] = 24'd4;
    req_radicand[1*W +: W] = 24'd9;
    req_radicand[3*W +: W] = 24'd16;
    rsp_ready = '1;
    req_valid = 4'b1011;
    nseen     = 0;
    cyc       = 0;
    r2_ready  = 1'b0;
    order     = '{default: 99};
    while (nseen < 6 && cyc < 300) begin
      @(negedge clk);
      #1;
      cyc++;
      if (req_ready[2]) r2_ready = 1'b1;
      hs = req_valid & req_ready;
      if (hs != '0) begin
        g = 99;
        for (int unsigned k = 0; k < N; k++) if (hs[k]) g = k;
        order[nseen] = g;
        nseen++;
      end
    end
    req_valid = '0;
    check("fair_grant_count", 64'(nseen), 64'd6);
    for (int unsigned i = 0; i < 6; i++)
      check("fair_grant_order", 64'(order[i]), 64'(exp_order[i]));
    check("fair_req2_never_ready", 64'(r2_ready), 64'd0);
    cyc = 0;
    while (busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("fair_drain", 64'(busy), 64'd0);
    rsp_ready = '0;

    // Reset three cycles after the start pulse
    @(negedge clk);
    req_radicand[0*W +: W] = 24'd144;
    req_valid[0] = 1'b1;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (sq_valid_in) seen = 1'b1;
    end
    check("mid_wait_start_seen", 64'(seen), 64'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_rsp_data", 64'(rsp_data), 64'd0);
    check("mid_rst_sq_valid_in", 64'(sq_valid_in), 64'd0);
    check("mid_rst_sq_radicand", 64'(sq_radicand), 64'd0);
    check("mid_rst_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    stray_pulse = 1'b1;
    @(negedge clk);
    stray_pulse = 1'b0;
    seen = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid != '0 || busy) seen = 1'b1;
    end
    check("stray_done_ignored", 64'(seen), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
